branch_ctrl: RTL and testbench

Branch/flow-control unit that drives the program counter's jump interface (jump_addr, CON, FS, jump_enable). It decodes the instruction fetched at PC_ADDR and resolves conditional jumps against a registered flag file with same-cycle ALU forwarding. It also maintains a small return-address stack for CALL/RET and implements a HALT/RESUME state machine. It sits between instruction memory/ALU and the PC, and is the producer for every PC jump request.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/ret_stack.sv | 61 ++++++
 rtl/branch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg
//   Shared definitions for the branch/flow-control unit: opcode encodings,
//   the run/halt FSM state type and the jump_enable encodings seen by the PC.
package branch_pkg;

    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_JZ   = 4'b1001;
    localparam logic [3:0] OP_JNZ  = 4'b1010;
    localparam logic [3:0] OP_JC   = 4'b1011;
    localparam logic [3:0] OP_CALL = 4'b1100;
    localparam logic [3:0] OP_RET  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [1:0] JE_JUMP = 2'b10;
    localparam logic [1:0] JE_INC  = 2'b00;

endpackage

// File: rtl/ret_stack.sv
// ret_stack
//   Parameterised LIFO of return addresses with an occupancy count.
//   Pushes while full and pops while empty are ignored; the caller decides
//   what that means (error policy lives in branch_ctrl).
// Ports:
//   CLK, RST      clock, asynchronous active-low reset (empties the stack)
//   i_push/i_pop  push i_data / discard the top entry at the clock edge
//   i_data        value to push
//   o_top         current top entry (valid when !o_empty)
//   o_full        count == DEPTH
//   o_empty       count == 0
//   o_count       occupancy 0..DEPTH
module ret_stack #(
    parameter int AW    = 6,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [AW-1:0]            i_data,
    output logic [AW-1:0]            o_top,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW:0]   r_count;
    logic [PW-1:0] w_wr_idx;
    logic [PW-1:0] w_top_idx;

    // DEPTH is a power of two, so the low PW bits of the count index the
    // next free slot; the top lives one below it (wraps correctly when full).
    assign w_wr_idx  = r_count[PW-1:0];
    assign w_top_idx = r_count[PW-1:0] - PW'(1);

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_top   = r_mem[w_top_idx];
    assign o_count = r_count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_count <= r_count + (PW+1)'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - (PW+1)'(1);
        end
    end

    // Storage needs no reset: entries above the count are never observed.
    always_ff @(posedge CLK) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl
//   Drives the PC jump interface. Decodes INSTR combinationally, resolves
//   conditional jumps against registered Z/C flags (with same-cycle
//   forwarding from the ALU), keeps a return-address stack for CALL/RET and
//   runs a RUN/HALTED state machine.
//   PC interface contract: each cycle the PC samples jump_enable at the clock
//   edge; 2'b10 loads jump_addr, 2'b00 increments. There is no back-pressure,
//   so every request is acted on at the very edge it is presented.
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   PC_ADDR         current program counter
//   INSTR           instruction at PC_ADDR
//   FLAG_WE, Z_IN, C_IN  ALU flag write strobe and results
//   RESUME          leave the HALTED state
//   jump_addr, CON, FS, jump_enable  PC jump request
//   HALTED          registered halt indication
//   STK_ERR         sticky stack overflow/underflow
//   o_dbg_state     FSM state
//   o_dbg_count     return-stack occupancy
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int AW        = 6,
    parameter int IW        = 16,
    parameter int STK_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [AW-1:0]              PC_ADDR,
    input  logic [IW-1:0]              INSTR,
    input  logic                       FLAG_WE,
    input  logic                       Z_IN,
    input  logic                       C_IN,
    input  logic                       RESUME,
    output logic [AW-1:0]              jump_addr,
    output logic                       CON,
    output logic                       FS,
    output logic [1:0]                 jump_enable,
    output logic                       HALTED,
    output logic                       STK_ERR,
    output state_t                     o_dbg_state,
    output logic [$clog2(STK_DEPTH):0] o_dbg_count
);
    state_t        r_state, w_state_nxt;
    logic          r_z, r_c, r_stk_err;
    logic [AW-1:0] r_halt_pc;

    logic [3:0]    w_op;
    logic [AW-1:0] w_tgt, w_ret_addr, w_top;
    logic          w_z_eff, w_c_eff;
    logic          w_full, w_empty;
    logic          w_push, w_pop, w_err_set, w_halt_ld;
    logic [1:0]    w_je;
    logic          w_con, w_fs;
    logic [AW-1:0] w_addr;
    logic          w_unused;

    assign w_op       = INSTR[IW-1:IW-4];
    assign w_tgt      = INSTR[AW-1:0];
    assign w_unused   = ^INSTR[IW-5:AW];
    assign w_ret_addr = PC_ADDR + AW'(1);   // wraps modulo 2^AW

    // Forwarding: a flag being written this cycle decides this cycle's branch.
    assign w_z_eff = FLAG_WE ? Z_IN : r_z;
    assign w_c_eff = FLAG_WE ? C_IN : r_c;

    ret_stack #(.AW(AW), .DEPTH(STK_DEPTH)) u_stack (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_ret_addr),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_dbg_count)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_RUN;
            r_z       <= 1'b0;
            r_c       <= 1'b0;
            r_halt_pc <= '0;
            r_stk_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (FLAG_WE) begin
                r_z <= Z_IN;
                r_c <= C_IN;
            end
            if (w_halt_ld) r_halt_pc <= PC_ADDR;
            if (w_err_set) r_stk_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_je        = JE_INC;
        w_con       = 1'b0;
        w_fs        = 1'b0;
        w_addr      = '0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err_set   = 1'b0;
        w_halt_ld   = 1'b0;
        case (r_state)
            ST_RUN: begin
                case (w_op)
                    OP_JMP: begin
                        w_je   = JE_JUMP;
                        w_addr = w_tgt;
                    end
                    OP_JZ, OP_JNZ, OP_JC: begin
                        w_con  = 1'b1;
                        w_addr = w_tgt;
                        if (w_op == OP_JZ)       w_fs = w_z_eff;
                        else if (w_op == OP_JNZ) w_fs = !w_z_eff;
                        else                     w_fs = w_c_eff;
                        // Not-taken must step the PC; a jump request with
                        // CON=1/FS=0 would make the PC refetch forever.
                        if (w_fs) w_je = JE_JUMP;
                    end
                    OP_CALL: begin
                        w_je   = JE_JUMP;
                        w_addr = w_tgt;
                        if (w_full) w_err_set = 1'b1;
                        else        w_push    = 1'b1;
                    end
                    OP_RET: begin
                        if (w_empty) begin
                            w_err_set = 1'b1;
                        end else begin
                            w_je   = JE_JUMP;
                            w_addr = w_top;
                            w_pop  = 1'b1;
                        end
                    end
                    OP_HALT: begin
                        w_je        = JE_JUMP;
                        w_addr      = PC_ADDR;
                        w_halt_ld   = 1'b1;
                        w_state_nxt = ST_HALTED;
                    end
                    default: ;
                endcase
            end
            ST_HALTED: begin
                // Parked on the HALT instruction; RESUME lets the PC step past it.
                if (RESUME) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_je   = JE_JUMP;
                    w_addr = r_halt_pc;
                end
            end
            default: ;
        endcase
    end

    // All outputs are forced quiet while reset is held.
    assign jump_enable = RST ? w_je   : JE_INC;
    assign CON         = RST ? w_con  : 1'b0;
    assign FS          = RST ? w_fs   : 1'b0;
    assign jump_addr   = RST ? w_addr : '0;
    assign HALTED      = RST && (r_state == ST_HALTED);
    assign STK_ERR     = r_stk_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
    import branch_pkg::*;

    localparam int AW = 6;

    logic          CLK;
    logic          RST;
    logic [AW-1:0] PC_ADDR;
    logic [15:0]   INSTR;
    logic          FLAG_WE, Z_IN, C_IN, RESUME;
    logic [AW-1:0] jump_addr;
    logic          CON, FS;
    logic [1:0]    jump_enable;
    logic          HALTED, STK_ERR;
    state_t        dbg_state;
    logic [2:0]    dbg_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected return-address stack (model of the DUT's LIFO).
    logic [AW-1:0] exp_q[$];

    branch_ctrl #(.AW(AW), .IW(16), .STK_DEPTH(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PC_ADDR     (PC_ADDR),
        .INSTR       (INSTR),
        .FLAG_WE     (FLAG_WE),
        .Z_IN        (Z_IN),
        .C_IN        (C_IN),
        .RESUME      (RESUME),
        .jump_addr   (jump_addr),
        .CON         (CON),
        .FS          (FS),
        .jump_enable (jump_enable),
        .HALTED      (HALTED),
        .STK_ERR     (STK_ERR),
        .o_dbg_state (dbg_state),
        .o_dbg_count (dbg_count)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_jump(input string tag, input logic con, input logic fs, input logic [AW-1:0] addr);
        check({tag, ".je"},   32'(jump_enable), 32'(JE_JUMP));
        check({tag, ".con"},  32'(CON),  32'(con));
        check({tag, ".fs"},   32'(FS),   32'(fs));
        check({tag, ".addr"}, 32'(jump_addr), 32'(addr));
    endtask

    task automatic chk_inc(input string tag, input logic con, input logic fs);
        check({tag, ".je"},  32'(jump_enable), 32'(JE_INC));
        check({tag, ".con"}, 32'(CON), 32'(con));
        check({tag, ".fs"},  32'(FS),  32'(fs));
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, ".je"},     32'(jump_enable), 0);
        check({tag, ".con"},    32'(CON), 0);
        check({tag, ".fs"},     32'(FS), 0);
        check({tag, ".addr"},   32'(jump_addr), 0);
        check({tag, ".halted"}, 32'(HALTED), 0);
        check({tag, ".count"},  32'(dbg_count), 0);
    endtask

    // ---------------- drivers ----------------
    // Apply one cycle of inputs at the falling edge; outputs are sampled 1ns later.
    task automatic cyc(input logic [3:0] op, input logic [11:0] tgt, input logic [AW-1:0] pc,
                       input logic fwe, input logic z, input logic c, input logic res);
        @(negedge CLK);
        INSTR   = {op, tgt};
        PC_ADDR = pc;
        FLAG_WE = fwe;
        Z_IN    = z;
        C_IN    = c;
        RESUME  = res;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_all_zero("reset");
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic do_call(input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
        cyc(OP_CALL, 12'(tgt), pc, 1'b0, 1'b0, 1'b0, 1'b0);
        check("call.count", 32'(dbg_count), 32'(exp_q.size()));
        chk_jump("call", 1'b0, 1'b0, tgt);
        if (exp_q.size() < 4) exp_q.push_back(pc + 6'd1);
    endtask

    task automatic do_ret(input logic [AW-1:0] pc);
        logic [AW-1:0] exp_addr;
        cyc(OP_RET, 12'h000, pc, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ret.count", 32'(dbg_count), 32'(exp_q.size()));
        if (exp_q.size() > 0) begin
            exp_addr = exp_q.pop_back();
            chk_jump("ret", 1'b0, 1'b0, exp_addr);
        end else begin
            chk_inc("ret_empty", 1'b0, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b0; PC_ADDR = '0; INSTR = {OP_JMP, 12'h02A};
        FLAG_WE = 0; Z_IN = 0; C_IN = 0; RESUME = 0;
        #1;
        chk_all_zero("por");
        check("por.stk_err", 32'(STK_ERR), 0);
        check("por.state", 32'(dbg_state), 32'(ST_RUN));
        @(negedge CLK);
        RST = 1'b1;

        // Unconditional jump
        cyc(OP_JMP, 12'h02A, 6'd5, 0, 0, 0, 0);
        chk_jump("jmp", 1'b0, 1'b0, 6'd42);

        // Conditional jumps with forwarding and registered flags
        cyc(OP_JZ, 12'h010, 6'd6, 1, 1, 0, 0);           // Z_R -> 1
        chk_jump("jz_fwd1", 1'b1, 1'b1, 6'd16);
        cyc(OP_JZ, 12'h010, 6'd7, 1, 0, 0, 0);           // Z_R -> 0
        chk_inc("jz_fwd0", 1'b1, 1'b0);
        cyc(OP_JNZ, 12'h033, 6'd8, 0, 1, 1, 0);          // uses Z_R=0
        chk_jump("jnz_reg", 1'b1, 1'b1, 6'd51);
        cyc(4'h0, 12'h000, 6'd9, 1, 0, 1, 0);            // NOP, C_R -> 1
        chk_inc("nop", 1'b0, 1'b0);
        cyc(OP_JC, 12'h005, 6'd10, 0, 0, 0, 0);          // uses C_R=1
        chk_jump("jc_reg", 1'b1, 1'b1, 6'd5);
        cyc(OP_JZ, 12'h005, 6'd11, 0, 1, 1, 0);          // uses Z_R=0
        chk_inc("jz_reg0", 1'b1, 1'b0);
        cyc(OP_JNZ, 12'h007, 6'd12, 1, 1, 0, 0);         // Z_R -> 1, C_R -> 0
        chk_inc("jnz_fwd", 1'b1, 1'b0);
        cyc(OP_JC, 12'h007, 6'd13, 0, 0, 1, 0);          // uses C_R=0
        chk_inc("jc_reg0", 1'b1, 1'b0);

        // Nested calls: returns to 10 then 4, then underflow
        check("nest.stk_err0", 32'(STK_ERR), 0);
        do_call(6'd3, 6'h08);
        do_call(6'd9, 6'h20);
        do_ret(6'h20);
        do_ret(6'h21);
        do_ret(6'h22);
        cyc(4'h0, 12'h000, 6'd40, 0, 0, 0, 0);
        check("underflow.stk_err", 32'(STK_ERR), 1);
        cyc(4'h0, 12'h000, 6'd41, 0, 0, 0, 0);
        check("underflow.sticky", 32'(STK_ERR), 1);

        // Overflow and return-address wrap
        do_reset();
        check("ovf.stk_err0", 32'(STK_ERR), 0);
        do_call(6'd60, 6'd1);
        do_call(6'd61, 6'd1);
        do_call(6'd62, 6'd1);
        do_call(6'd63, 6'd1);                            // pushes 0
        do_call(6'd20, 6'h15);                           // dropped, still jumps
        cyc(4'h0, 12'h000, 6'd22, 0, 0, 0, 0);
        check("ovf.stk_err", 32'(STK_ERR), 1);
        check("ovf.count", 32'(dbg_count), 4);
        do_ret(6'd23);                                   // -> 0
        do_ret(6'd0);                                    // -> 63

        // HALT / RESUME
        do_reset();
        cyc(OP_HALT, 12'h000, 6'd12, 0, 0, 0, 0);
        chk_jump("halt", 1'b0, 1'b0, 6'd12);
        check("halt.halted0", 32'(HALTED), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(OP_CALL, 12'h02A, 6'd12, 0, 0, 0, 0);   // ignored while halted
            check("halted.halted", 32'(HALTED), 1);
            chk_jump("halted", 1'b0, 1'b0, 6'd12);
            check("halted.count", 32'(dbg_count), 0);
        end
        cyc(OP_JMP, 12'h02A, 6'd12, 0, 0, 0, 1);
        chk_inc("resume", 1'b0, 1'b0);
        check("resume.halted", 32'(HALTED), 1);
        cyc(4'h0, 12'h000, 6'd13, 0, 0, 0, 1);          // RESUME ignored in RUN
        check("run.halted", 32'(HALTED), 0);
        check("run.count", 32'(dbg_count), 0);
        chk_inc("run_resume", 1'b0, 1'b0);
        cyc(4'h0, 12'h000, 6'd14, 0, 0, 0, 0);
        check("run2.state", 32'(dbg_state), 32'(ST_RUN));

        // Reset while halted with two stack entries
        do_call(6'd1, 6'd5);
        do_call(6'd6, 6'd9);
        cyc(OP_HALT, 12'h000, 6'd9, 0, 0, 0, 0);
        chk_jump("halt2", 1'b0, 1'b0, 6'd9);
        cyc(4'h0, 12'h000, 6'd9, 0, 0, 0, 0);
        check("halt2.halted", 32'(HALTED), 1);
        check("halt2.count", 32'(dbg_count), 2);
        #2;
        RST = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b1;
        do_ret(6'd20);
        cyc(4'h0, 12'h000, 6'd21, 0, 0, 0, 0);
        check("post_reset.stk_err", 32'(STK_ERR), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
